// File: rtl/mult_unit.sv
// Iterative shift-add HI/LO multiplier: one add/shift step per cycle over WIDTH cycles,
// then a sign-correct/commit cycle. hi/lo change only on commit.
module mult_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    typedef struct packed {
        logic             neg;
        logic [WIDTH-1:0] mag_a;
        logic [WIDTH-1:0] mag_b;
    } req_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic               neg;
    // Upper half: partial product; lower half: multiplier bits not yet consumed.
    logic [2*WIDTH-1:0] acc;

    req_t               req;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] product;

    always_comb begin
        req.neg   = mult_sign & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        req.mag_a = (mult_sign && op_a[WIDTH-1]) ? -op_a : op_a;
        req.mag_b = (mult_sign && op_b[WIDTH-1]) ? -op_b : op_b;
    end

    // Carry out of the add lands in the MSB after the shift, so no bit is lost.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_step = {sum, acc[WIDTH-1:1]};
        product  = neg ? -acc : acc;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        mcand <= req.mag_a;
                        neg   <= req.neg;
                        acc   <= {{WIDTH{1'b0}}, req.mag_b};
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= FINISH;
                end
                FINISH: begin
                    hi    <= product[2*WIDTH-1:WIDTH];
                    lo    <= product[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: expected products are queued at request time and
// compared by a monitor whenever done pulses.
module tb_mult_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_mult = 1'b0;
    logic         mult_sign = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [2*W-1:0] sb[$];
    logic [2*W-1:0] exp_prod;

    mult_unit #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start_mult(start_mult), .mult_sign(mult_sign),
        .op_a(op_a), .op_b(op_b), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb_;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb_ = {{W{b[W-1]}}, b};
            return sa * sb_;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done hi=%h lo=%h (no result expected)", hi, lo);
            end else begin
                exp_prod = sb.pop_front();
                if ({hi, lo} !== exp_prod) begin
                    errors++;
                    $display("FAIL product got=%h_%h exp=%h_%h", hi, lo, exp_prod[2*W-1:W], exp_prod[W-1:0]);
                end
            end
        end
    end

    // Pulses start for one cycle; returns at the negedge right after the sampling edge.
    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clk);
        start_mult = 1'b1; mult_sign = s; op_a = a; op_b = b;
        if (push) sb.push_back(model(s, a, b));
        @(negedge clk);
        start_mult = 1'b0; mult_sign = 1'bx; op_a = 'x; op_b = 'x;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout done=%b exp=1", name, done);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({hi, lo, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state hi=%h lo=%h busy=%b done=%b exp all 0", hi, lo, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        start_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        for (int c = 1; c <= 33; c++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL busy_cycle%0d busy=%b done=%b exp busy=1 done=0", c, busy, done);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL latency_cycle34 done=%b busy=%b hi=%h lo=%h exp 1 0 ffffffff ffffffeb", done, busy, hi, lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width done=%b exp=0", done);
        end
    endtask

    task automatic test_corners();
        start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done("umax");
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL umax hi=%h lo=%h exp fffffffe 00000001", hi, lo);
        end
        start_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done("sneg1");
        start_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_done("smin_sq");
        checks++;
        if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
            errors++;
            $display("FAIL smin_sq hi=%h lo=%h exp 40000000 00000000", hi, lo);
        end
        start_op(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1); wait_done("smin_x1");
        for (int i = 0; i < 6; i++) begin
            start_op(1'(i & 1), $urandom, $urandom, 1'b1);
            wait_done("random");
        end
    endtask

    task automatic test_ignored_start();
        int dc;
        do_reset();
        dc = done_cnt;
        start_op(1'b0, 32'd5, 32'd6, 1'b1);
        repeat (8) @(negedge clk);
        start_mult = 1'b1; mult_sign = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start_mult = 1'b0;
        while (!done && busy) begin
            checks++;
            if (hi !== '0 || lo !== '0) begin
                errors++;
                $display("FAIL hold_during_run hi=%h lo=%h exp 0 0", hi, lo);
            end
            @(negedge clk);
        end
        wait_done("ignored");
        checks++;
        if (lo !== 32'h1E) begin
            errors++;
            $display("FAIL ignored_lo lo=%h exp 0000001e", lo);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt - dc !== 1) begin
            errors++;
            $display("FAIL single_done pulses=%0d exp 1", done_cnt - dc);
        end
    endtask

    task automatic test_abort();
        int dc, n;
        do_reset();
        start_op(1'b0, 32'd7, 32'd8, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL abort_state busy=%b done=%b hi=%h lo=%h exp all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        dc = done_cnt;
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt !== dc || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done pulses=%0d busy=%b exp 0 0", done_cnt - dc, busy);
        end
        start_op(1'b0, 32'd2, 32'd3, 1'b1);
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 34 || lo !== 32'd6) begin
            errors++;
            $display("FAIL abort_restart cycle=%0d lo=%h exp 34 00000006", n, lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(1'b0, 32'd4, 32'd5, 1'b1);
        wait_done("b2b_first");
        start_mult = 1'b1; mult_sign = 1'b0; op_a = 32'd10; op_b = 32'd10;
        sb.push_back(model(1'b0, 32'd10, 32'd10));
        @(negedge clk);
        start_mult = 1'b0;
        checks++;
        if (busy !== 1'b1 || hi !== '0 || lo !== 32'h14) begin
            errors++;
            $display("FAIL b2b_accept busy=%b hi=%h lo=%h exp 1 0 00000014", busy, hi, lo);
        end
        n = 1;
        while (!done && n < 60) begin
            checks++;
            if (hi !== '0 || lo !== 32'h14) begin
                errors++;
                $display("FAIL b2b_hold hi=%h lo=%h exp 0 00000014", hi, lo);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 34 || lo !== 32'h64 || hi !== '0) begin
            errors++;
            $display("FAIL b2b_second cycle=%0d hi=%h lo=%h exp 34 0 00000064", n, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_corners();
        test_ignored_start();
        test_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
